// File: rtl/alarm_sched_pkg.sv
// rtl/alarm_sched_pkg.sv - shared types and default constants for the alarm scheduler
package alarm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RING   = 2'b01,
    ST_SNOOZE = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0] h1;
    logic [3:0] h0;
    logic [3:0] m1;
    logic [3:0] m0;
  } hhmm_t;

  localparam int DEF_N_SLOTS    = 4;
  localparam int DEF_SNOOZE_SEC = 300;
  localparam int DEF_RING_SEC   = 60;
  localparam int DEF_MAX_SNOOZE = 3;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_slot_bank.sv
// rtl/alarm_slot_bank.sv - alarm slot register file with per-slot time comparators
module alarm_slot_bank
  import alarm_sched_pkg::*;
#(
  parameter int N_SLOTS = DEF_N_SLOTS,
  parameter int SLOT_W  = $clog2(N_SLOTS)
) (
  input  logic               clk_1s,
  input  logic               reset,
  input  logic               cfg_we,
  input  logic [SLOT_W-1:0]  cfg_slot,
  input  logic [1:0]         cfg_h1,
  input  logic [3:0]         cfg_h0,
  input  logic [3:0]         cfg_m1,
  input  logic [3:0]         cfg_m0,
  input  logic               cfg_en,
  input  logic               al_on,
  input  logic [1:0]         cur_h1,
  input  logic [3:0]         cur_h0,
  input  logic [3:0]         cur_m1,
  input  logic [3:0]         cur_m0,
  input  logic [3:0]         cur_s1,
  input  logic [3:0]         cur_s0,
  output logic [N_SLOTS-1:0] match
);

  hhmm_t              slot_time [N_SLOTS];
  logic [N_SLOTS-1:0] slot_en;
  hhmm_t              cur_hhmm;

  assign cur_hhmm = {cur_h1, cur_h0, cur_m1, cur_m0};

  // Slot storage; the comparators see the pre-edge contents, so a write that
  // coincides with a match on the same slot does not affect that match.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        slot_time[i] <= '0;
      end
      slot_en <= '0;
    end else if (cfg_we && (int'(cfg_slot) < N_SLOTS)) begin
      slot_time[cfg_slot] <= {cfg_h1, cfg_h0, cfg_m1, cfg_m0};
      slot_en[cfg_slot]   <= cfg_en;
    end
  end

  // Exact-bit HH:MM compare, only in the :00 second so each alarm fires once.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      match[i] = slot_en[i] & al_on & (slot_time[i] == cur_hhmm) &
                 (cur_s1 == 4'd0) & (cur_s0 == 4'd0);
    end
  end

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-slot alarm FSM with ring, snooze, timeout and pending queue
module alarm_scheduler
  import alarm_sched_pkg::*;
#(
  parameter int N_SLOTS    = DEF_N_SLOTS,
  parameter int SNOOZE_SEC = DEF_SNOOZE_SEC,
  parameter int RING_SEC   = DEF_RING_SEC,
  parameter int MAX_SNOOZE = DEF_MAX_SNOOZE,
  parameter int SLOT_W     = $clog2(N_SLOTS)
) (
  input  logic               clk_1s,
  input  logic               reset,
  input  logic [1:0]         cur_h1,
  input  logic [3:0]         cur_h0,
  input  logic [3:0]         cur_m1,
  input  logic [3:0]         cur_m0,
  input  logic [3:0]         cur_s1,
  input  logic [3:0]         cur_s0,
  input  logic               cfg_we,
  input  logic [SLOT_W-1:0]  cfg_slot,
  input  logic [1:0]         cfg_h1,
  input  logic [3:0]         cfg_h0,
  input  logic [3:0]         cfg_m1,
  input  logic [3:0]         cfg_m0,
  input  logic               cfg_en,
  input  logic               al_on,
  input  logic               stop,
  input  logic               snooze,
  output logic               alarm,
  output logic [SLOT_W-1:0]  active_slot,
  output logic [1:0]         state,
  output logic [N_SLOTS-1:0] pending
);

  localparam int CNT_MAX = max2(SNOOZE_SEC, RING_SEC);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int SNZ_W   = $clog2(MAX_SNOOZE + 1);

  localparam logic [CNT_W-1:0] CNT_TOP     = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SEC - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SEC - 1);
  localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(MAX_SNOOZE);
  localparam logic [N_SLOTS-1:0] ONE_HOT0  = N_SLOTS'(1);

  state_t             state_q, state_d;
  logic               alarm_q, alarm_d;
  logic [SLOT_W-1:0]  active_q, active_d;
  logic [N_SLOTS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   ring_cnt, ring_d;
  logic [CNT_W-1:0]   wait_cnt, wait_d;
  logic [SNZ_W-1:0]   snz_cnt, snz_d;

  logic [N_SLOTS-1:0] match;
  logic [N_SLOTS-1:0] cand;
  logic [SLOT_W-1:0]  pick;
  logic [N_SLOTS-1:0] pick_mask;
  logic [N_SLOTS-1:0] active_mask;

  alarm_slot_bank #(
    .N_SLOTS (N_SLOTS),
    .SLOT_W  (SLOT_W)
  ) u_bank (
    .clk_1s   (clk_1s),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_slot (cfg_slot),
    .cfg_h1   (cfg_h1),
    .cfg_h0   (cfg_h0),
    .cfg_m1   (cfg_m1),
    .cfg_m0   (cfg_m0),
    .cfg_en   (cfg_en),
    .al_on    (al_on),
    .cur_h1   (cur_h1),
    .cur_h0   (cur_h0),
    .cur_m1   (cur_m1),
    .cur_m0   (cur_m0),
    .cur_s1   (cur_s1),
    .cur_s0   (cur_s0),
    .match    (match)
  );

  assign cand        = match | pending_q;
  assign pick_mask   = ONE_HOT0 << pick;
  assign active_mask = ONE_HOT0 << active_q;

  // Lowest-index priority pick among fresh matches and queued slots.
  always_comb begin
    pick = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (cand[i]) pick = SLOT_W'(i);
    end
  end

  // Next-state and next-output decisions from the inputs sampled this edge.
  always_comb begin
    state_d   = state_q;
    alarm_d   = alarm_q;
    active_d  = active_q;
    pending_d = pending_q;
    ring_d    = ring_cnt;
    wait_d    = wait_cnt;
    snz_d     = snz_cnt;
    if (!al_on) begin
      state_d   = ST_IDLE;
      alarm_d   = 1'b0;
      pending_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|cand) begin
            state_d   = ST_RING;
            alarm_d   = 1'b1;
            active_d  = pick;
            pending_d = cand & ~pick_mask;
            ring_d    = '0;
            snz_d     = '0;
          end
        end
        ST_RING: begin
          pending_d = pending_q | (match & ~active_mask);
          ring_d    = (ring_cnt == CNT_TOP) ? ring_cnt : ring_cnt + CNT_W'(1);
          if (stop) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
          end else if (snooze && (snz_cnt < SNZ_LIMIT)) begin
            state_d = ST_SNOOZE;
            alarm_d = 1'b0;
            snz_d   = snz_cnt + SNZ_W'(1);
            wait_d  = '0;
          end else if (ring_cnt == RING_LAST) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
          end
        end
        ST_SNOOZE: begin
          pending_d = pending_q | (match & ~active_mask);
          wait_d    = (wait_cnt == CNT_TOP) ? wait_cnt : wait_cnt + CNT_W'(1);
          if (stop) begin
            state_d = ST_IDLE;
            alarm_d = 1'b0;
          end else if (wait_cnt == SNOOZE_LAST) begin
            state_d = ST_RING;
            alarm_d = 1'b1;
            ring_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          alarm_d = 1'b0;
        end
      endcase
    end
  end

  // State, output and counter registers; reset returns everything to idle at once.
  always_ff @(posedge clk_1s or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      alarm_q   <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
      ring_cnt  <= '0;
      wait_cnt  <= '0;
      snz_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      alarm_q   <= alarm_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      ring_cnt  <= ring_d;
      wait_cnt  <= wait_d;
      snz_cnt   <= snz_d;
    end
  end

  assign alarm       = alarm_q;
  assign active_slot = active_q;
  assign state       = state_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// tb/tb_alarm_scheduler.sv - scoreboard testbench for alarm_scheduler
module tb_alarm_scheduler;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_SEC = 300;
  localparam int MAX_SNOOZE = 3;

  logic       clk_1s = 1'b0;
  logic       reset;
  logic [1:0] cur_h1;
  logic [3:0] cur_h0, cur_m1, cur_m0, cur_s1, cur_s0;
  logic       cfg_we;
  logic [1:0] cfg_slot;
  logic [1:0] cfg_h1;
  logic [3:0] cfg_h0, cfg_m1, cfg_m0;
  logic       cfg_en, al_on, stop, snooze;
  logic       alarm;
  logic [1:0] active_slot;
  logic [1:0] state;
  logic [3:0] pending;

  alarm_scheduler dut (
    .clk_1s(clk_1s), .reset(reset),
    .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
    .cur_s1(cur_s1), .cur_s0(cur_s0),
    .cfg_we(cfg_we), .cfg_slot(cfg_slot),
    .cfg_h1(cfg_h1), .cfg_h0(cfg_h0), .cfg_m1(cfg_m1), .cfg_m0(cfg_m0),
    .cfg_en(cfg_en), .al_on(al_on), .stop(stop), .snooze(snooze),
    .alarm(alarm), .active_slot(active_slot), .state(state), .pending(pending)
  );

  always #5 clk_1s = ~clk_1s;

  typedef struct {
    bit       alarm;
    int       st;
    int       act;
    bit [3:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tsec = 0;
  int   ecount = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing; timing by edge stamps.
  int       m_mode = 0, m_act = 0, m_snz = 0, ring_start = 0, snz_start = 0;
  bit [3:0] m_pend = 0;
  bit [1:0] s_h1 [4];
  bit [3:0] s_h0 [4], s_m1 [4], s_m0 [4];
  bit       s_en [4];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive_time();
    int hh, mm, ss;
    hh = tsec / 3600; mm = (tsec / 60) % 60; ss = tsec % 60;
    cur_h1 = 2'(hh / 10); cur_h0 = 4'(hh % 10);
    cur_m1 = 4'(mm / 10); cur_m0 = 4'(mm % 10);
    cur_s1 = 4'(ss / 10); cur_s0 = 4'(ss % 10);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    tsec = h * 3600 + m * 60 + s;
    drive_time();
  endtask

  task automatic write_slot(input int slot, input int h, input int m, input bit en);
    cfg_we = 1'b1; cfg_slot = 2'(slot); cfg_en = en;
    cfg_h1 = 2'(h / 10); cfg_h0 = 4'(h % 10); cfg_m1 = 4'(m / 10); cfg_m0 = 4'(m % 10);
  endtask

  task automatic model_step();
    bit [3:0] m;
    bit [3:0] one;
    exp_t     e;
    one = 4'b0001;
    for (int i = 0; i < 4; i++)
      m[i] = s_en[i] && al_on && s_h1[i] == cur_h1 && s_h0[i] == cur_h0 &&
             s_m1[i] == cur_m1 && s_m0[i] == cur_m0 && cur_s1 == 0 && cur_s0 == 0;
    if (reset) begin
      m_mode = 0; m_act = 0; m_pend = 0; m_snz = 0;
      for (int i = 0; i < 4; i++) begin
        s_h1[i] = 0; s_h0[i] = 0; s_m1[i] = 0; s_m0[i] = 0; s_en[i] = 0;
      end
    end else begin
      if (!al_on) begin
        m_mode = 0; m_pend = 0;
      end else if (m_mode == 0) begin
        if ((m | m_pend) != 0) begin
          m_act = lowest(m | m_pend);
          m_pend = (m | m_pend) & ~(one << m_act);
          m_mode = 1; ring_start = ecount; m_snz = 0;
        end
      end else begin
        m_pend = m_pend | (m & ~(one << m_act));
        if (stop) m_mode = 0;
        else if (m_mode == 1) begin
          if (snooze && m_snz < MAX_SNOOZE) begin
            m_mode = 2; m_snz++; snz_start = ecount;
          end else if (ecount - ring_start == RING_SEC) m_mode = 0;
        end else if (ecount - snz_start == SNOOZE_SEC) begin
          m_mode = 1; ring_start = ecount;
        end
      end
      if (cfg_we) begin
        s_h1[cfg_slot] = cfg_h1; s_h0[cfg_slot] = cfg_h0;
        s_m1[cfg_slot] = cfg_m1; s_m0[cfg_slot] = cfg_m0; s_en[cfg_slot] = cfg_en;
      end
    end
    e.alarm = (m_mode == 1); e.st = m_mode; e.act = m_act; e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  // One second: model the edge, let the DUT take it, then advance the clock digits.
  task automatic tick();
    model_step();
    @(posedge clk_1s);
    @(negedge clk_1s);
    ecount++;
    tsec = (tsec + 1) % 86400;
    drive_time();
    cfg_we = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every edge the registered outputs are compared against the queued expectation.
  always begin
    exp_t e;
    @(posedge clk_1s);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("alarm", alarm, e.alarm);
      chk("state", state, e.st);
      chk("pending", pending, e.pend);
      if (e.st != 0) chk("active_slot", active_slot, e.act);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_we = 0; cfg_slot = 0; cfg_h1 = 0; cfg_h0 = 0; cfg_m1 = 0; cfg_m0 = 0;
    cfg_en = 0; al_on = 0; stop = 0; snooze = 0;
    set_time(0, 0, 0);
    repeat (2) @(negedge clk_1s);
    chk("reset_alarm", alarm, 0);
    chk("reset_state", state, 0);
    chk("reset_active", active_slot, 0);
    chk("reset_pending", pending, 0);
    model_step();
    void'(exp_q.pop_front());
    reset = 1'b0;
    al_on = 1'b1;

    // Single slot rings at 07:30:00, stopped five seconds later.
    set_time(7, 29, 50);
    write_slot(1, 7, 30, 1'b1);
    tick();
    ticks(14);
    stop = 1'b1;
    ticks(4);

    // Two slots at 06:00: slot 0 first, slot 2 queued and served after stop.
    set_time(5, 59, 50);
    write_slot(0, 6, 0, 1'b1); tick();
    write_slot(2, 6, 0, 1'b1); tick();
    write_slot(1, 23, 59, 1'b0); tick();
    ticks(10);
    stop = 1'b1; tick();
    ticks(3);
    stop = 1'b1; tick();
    ticks(3);

    // Snooze three times, fourth request ignored, then timeout.
    write_slot(0, 8, 0, 1'b1); tick();
    write_slot(2, 8, 0, 1'b0); tick();
    set_time(7, 59, 58);
    ticks(4);
    for (int k = 0; k < 4; k++) begin
      snooze = 1'b1; tick();
      if (k < 3) ticks(SNOOZE_SEC + 1);
    end
    ticks(RING_SEC + 5);

    // Plain timeout with no requests.
    set_time(8, 59, 58);
    write_slot(3, 9, 0, 1'b1); tick();
    ticks(RING_SEC + 5);

    // stop and snooze together; then al_on dropped during snooze with a pending slot.
    set_time(9, 59, 58);
    write_slot(1, 10, 1, 1'b1); tick();
    write_slot(0, 10, 0, 1'b1); tick();
    ticks(3);
    stop = 1'b1; snooze = 1'b1; tick();
    set_time(10, 0, 58);
    write_slot(0, 10, 1, 1'b1); tick();
    ticks(2);
    snooze = 1'b1; tick();
    set_time(10, 0, 58);
    write_slot(3, 10, 1, 1'b1); tick();
    ticks(5);
    al_on = 1'b0; tick();
    ticks(2);
    al_on = 1'b1; ticks(2);

    // Reset mid-ring clears slots; 07:30 no longer rings.
    set_time(7, 29, 58);
    write_slot(1, 7, 30, 1'b1); tick();
    ticks(5);
    reset = 1'b1;
    #1;
    chk("midreset_alarm", alarm, 0);
    chk("midreset_state", state, 0);
    chk("midreset_pending", pending, 0);
    chk("midreset_active", active_slot, 0);
    tick();
    reset = 1'b0;
    set_time(7, 29, 58);
    ticks(6);

    // Randomized traffic around slot times.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        int t2;
        t2 = (tsec + $urandom_range(0, 150)) % 86400;
        write_slot($urandom_range(0, 3), t2 / 3600, (t2 / 60) % 60, $urandom_range(0, 3) != 0);
        if ($urandom_range(0, 9) == 0) cfg_h0 = 4'hF;
      end
      if ($urandom_range(0, 24) == 0) stop = 1'b1;
      if ($urandom_range(0, 14) == 0) snooze = 1'b1;
      if (al_on) begin
        if ($urandom_range(0, 199) == 0) al_on = 1'b0;
      end else if ($urandom_range(0, 4) == 0) al_on = 1'b1;
      if ($urandom_range(0, 149) == 0) begin
        tsec = ((tsec / 60 + 1) * 60 - 2) % 86400;
        drive_time();
      end
      tick();
    end

    repeat (2) @(negedge clk_1s);
    chk("queue_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
